// File: rtl/multi_clk_counter.sv
// multi_clk_counter: per-channel prescaled interval counters with capture/ack handoff.
// Optional feature macro CLK_COUNTER_OVERRUN_EN adds sticky per-channel overrun flags.
module multi_clk_counter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       cap,
  input  logic [CHANNELS-1:0]       cap_ack,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS*WIDTH-1:0] cap_val,
  output logic [CHANNELS-1:0]       cap_valid,
  output logic [CHANNELS-1:0]       ovf
`ifdef CLK_COUNTER_OVERRUN_EN
  ,
  output logic [CHANNELS-1:0]       overrun
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOP = '1;

  logic [PW-1:0] psc;
  logic          tick;

  assign tick = (psc == PMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else begin
      psc <= psc + PW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cv;
    logic             vld;
    logic             of;
    logic             at_top;

    assign at_top = (cnt == TOP);

    // clr beats cap beats increment; a cap discards any same-cycle tick
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        cv  <= '0;
        vld <= 1'b0;
        of  <= 1'b0;
      end else if (clr[i]) begin
        cnt <= '0;
        vld <= 1'b0;
        of  <= 1'b0;
      end else if (cap[i]) begin
        cv  <= cnt;
        cnt <= '0;
        vld <= 1'b1;
        of  <= 1'b0;
      end else begin
        if (cap_ack[i]) begin
          vld <= 1'b0;
        end
        if (en[i] && tick) begin
          if (at_top) begin
            of <= 1'b1;
          end
          if (SATURATE == 0 || !at_top) begin
            cnt <= cnt + ONE;
          end
        end
      end
    end

    assign count[i*WIDTH +: WIDTH]   = cnt;
    assign cap_val[i*WIDTH +: WIDTH] = cv;
    assign cap_valid[i]              = vld;
    assign ovf[i]                    = of;

`ifdef CLK_COUNTER_OVERRUN_EN
    logic orun;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        orun <= 1'b0;
      end else if (clr[i]) begin
        orun <= 1'b0;
      end else if (cap[i] && vld && !cap_ack[i]) begin
        orun <= 1'b1;
      end
    end

    assign overrun[i] = orun;
`endif
  end

endmodule

// File: doc/multi_clk_counter.md
Name: multi_clk_counter

Overview:
Parametrised, multi-channel successor to the single free-running clock counter used by the position logic. Each channel counts prescaled clock ticks while enabled. Each channel can capture-and-restart on an event strobe, so it measures the interval between encoder or bump events. Captured values are handed to the position/odometry logic through a per-channel valid/ack handshake, with overflow reporting and selectable wrap or saturate arithmetic.

Parameters:
WIDTH, 32, counter and capture width per channel (2..64)
CHANNELS, 2, number of independent channels (1..8)
PRESCALE, 1, clk cycles per count tick (1..65535); 1 = count every enabled cycle
SATURATE, 0, 0 = wrap at 2^WIDTH-1 -> 0; 1 = hold at 2^WIDTH-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  CHANNELS  per-channel count enable, level
clr  in  CHANNELS  per-channel synchronous clear strobe
cap  in  CHANNELS  per-channel capture-and-restart strobe
cap_ack  in  CHANNELS  consumer acknowledge of cap_val
count  out  CHANNELS*WIDTH  live counters, channel i at [i*WIDTH +: WIDTH]
cap_val  out  CHANNELS*WIDTH  captured values, same packing
cap_valid  out  CHANNELS  capture pending, per channel
ovf  out  CHANNELS  sticky overflow (wrap or saturation) per channel

Behaviour:
- Reset (rst=0, asynchronous): count=0, cap_val=0, cap_valid=0, ovf=0, prescaler=0. All outputs are registered; no reset glitch path on release.
- Prescaler: single shared counter 0..PRESCALE-1.
  - tick=1 on the cycle it equals PRESCALE-1; it then returns to 0.
  - Free-running, independent of en.
  - PRESCALE=1 gives tick=1 every cycle.
- Per-channel priority, evaluated each cycle: clr > cap > increment.
  - clr=1: count<=0, ovf<=0, cap_valid<=0. cap_val is unchanged. Any cap on the same cycle is ignored.
  - cap=1 (clr=0): cap_val<=count (pre-increment value), count<=0, cap_valid<=1, ovf<=0. A tick on the same cycle is discarded.
  - Otherwise, if en=1 and tick=1, increment:
    - SATURATE=0: count<=count+1 mod 2^WIDTH; ovf<=1 on the cycle it wraps from all-ones.
    - SATURATE=1: at all-ones, count holds and ovf<=1; otherwise count<=count+1.
  - en=0: count holds. Ticks are lost, not queued.
- Latency: count reflects an increment 1 cycle after the tick edge. cap_val and cap_valid are visible 1 cycle after the cap edge.
- Handshake:
  - cap_valid stays 1 until a cycle with cap_ack=1; it then clears on the next edge.
  - cap_ack while cap_valid=0 is ignored.
  - cap and cap_ack on the same cycle: new cap_val is loaded and cap_valid stays 1, so the new capture is pending.
  - cap while cap_valid=1 and no ack: cap_val is overwritten with the newest value (see Optional Feature).
- Channels are fully independent. There is no cross-channel interaction except the shared prescaler.
- Width rules: all arithmetic is WIDTH bits unsigned. No truncation warnings are allowed. Counter add uses a WIDTH-bit constant 1.

Optional Feature:
CLK_COUNTER_OVERRUN_EN
- Defined:
  - Adds output port overrun [CHANNELS].
  - overrun[i] is set when cap[i]=1, cap_valid[i]=1 and cap_ack[i]=0 on the same cycle (unread capture overwritten).
  - overrun is sticky; it clears only on clr[i] or reset.
  - Overwrite policy is unchanged: newest value wins.
- Not defined: the port and its logic are absent; overwrites are silent.

Test Plan:
1. Reset/basic, CHANNELS=2, PRESCALE=1: release rst, en=2'b01 for 10 cycles -> count0=10, count1=0, all flags 0. Assert rst=0 mid-count -> count0=0 immediately, without waiting for a clock edge.
2. Prescale, PRESCALE=4: en=1 for 40 cycles -> count=10. Deassert en for 8 cycles -> count holds at 10.
3. Capture/handshake: count=25, pulse cap -> next cycle cap_val=25, count=0, cap_valid=1. Hold cap_ack=0 for 5 cycles -> cap_valid stays 1. Pulse cap_ack -> cap_valid=0 next cycle.
4. Overflow, WIDTH=4:
   - SATURATE=0: 17 ticks -> count=1, ovf=1.
   - SATURATE=1: 17 ticks -> count=15, ovf=1.
   - cap then clears ovf.
5. Priority: clr and cap asserted together at count=7 -> count=0, cap_valid=0, cap_val unchanged. Separately, cap and cap_ack together with cap_valid=1 -> cap_valid remains 1 with new cap_val.
6. CLK_COUNTER_OVERRUN_EN defined: two caps with no ack between them -> overrun=1, cap_val equals the second value. clr -> overrun=0.
